data_memory_responder: RTL and testbench

- Memory-side end of the pipeline's data-memory handshake.
- Accepts word write requests from the write stage (address_enable/address/data, answered by data_valid) and word read requests from the read stage.
- Arbitrates between the two and drives a single wait-request style memory bus. Returns one completion pulse per request.
- Sits between the pipeline stages and the data memory/bus fabric.

---
 rtl/data_memory_responder_pkg.sv | 22 ++
 rtl/data_memory_responder_if.sv | 39 +++
 rtl/data_memory_responder_timeout.sv | 33 +++
 rtl/data_memory_responder.sv | 124 ++++++++++++
 tb/tb_data_memory_responder.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data-memory responder: register value type,
// FSM state encoding and the "timeout disabled" marker.
package data_memory_responder_pkg;

  typedef logic [31:0] regval_t;

  typedef enum logic [2:0] {
    RS_IDLE      = 3'd0,
    RS_WRITE_CMD = 3'd1,
    RS_READ_CMD  = 3'd2,
    RS_READ_WAIT = 3'd3,
    RS_RESPOND   = 3'd4
  } responder_state_t;

  localparam int DeadlineNone = 0;

  // True while a request owns the bus and the timeout is counting.
  function automatic logic state_is_busy(input logic [2:0] state);
    return (state == RS_WRITE_CMD) || (state == RS_READ_CMD) || (state == RS_READ_WAIT);
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Pipeline request/response signals and wait-request memory bus, bundled so the
// responder and its environment share one connection point.
interface data_memory_responder_if #(
  parameter int ADDRESS_WIDTH = 30
);
  import data_memory_responder_pkg::*;

  logic                     address_enable;
  regval_t                  address;
  regval_t                  data;
  logic                     data_valid;
  logic                     read_enable;
  regval_t                  read_address;
  regval_t                  read_data;
  logic                     read_valid;
  logic                     bus_error;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic                     mem_write;
  logic                     mem_read;
  regval_t                  mem_write_data;
  logic                     mem_wait_request;
  regval_t                  mem_read_data;
  logic                     mem_read_data_valid;

  modport slave (
    input  address_enable, address, data, read_enable, read_address,
           mem_wait_request, mem_read_data, mem_read_data_valid,
    output data_valid, read_data, read_valid, bus_error,
           mem_address, mem_write, mem_read, mem_write_data
  );

  modport master (
    output address_enable, address, data, read_enable, read_address,
           mem_wait_request, mem_read_data, mem_read_data_valid,
    input  data_valid, read_data, read_valid, bus_error,
           mem_address, mem_write, mem_read, mem_write_data
  );

endinterface

// File: rtl/data_memory_responder_timeout.sv
// Saturating per-request cycle counter; flags the last allowed bus cycle of a request.
module data_memory_responder_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  import data_memory_responder_pkg::*;

  logic [31:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + 32'd1;
    end
  end

  // Expiry is asserted during the TIMEOUT_CYCLES-th busy cycle, so the strobe is
  // seen exactly TIMEOUT_CYCLES times before the forced completion.
  generate
    if (TIMEOUT_CYCLES == DeadlineNone) begin : g_no_timeout
      assign o_expired = 1'b0;
    end else begin : g_timeout
      assign o_expired = i_enable && (r_count >= 32'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder: arbitrates pipeline write/read requests onto a single
// wait-request bus and returns one registered completion pulse per request.
module data_memory_responder #(
  parameter int ADDRESS_WIDTH  = 30,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                   clock,
  input logic                   reset,
  data_memory_responder_if.slave bus
);
  import data_memory_responder_pkg::*;

  localparam logic [2:0] StIdle     = RS_IDLE;
  localparam logic [2:0] StWriteCmd = RS_WRITE_CMD;
  localparam logic [2:0] StReadCmd  = RS_READ_CMD;
  localparam logic [2:0] StReadWait = RS_READ_WAIT;
  localparam logic [2:0] StRespond  = RS_RESPOND;

  logic [2:0]               r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  regval_t                  r_wdata;
  logic                     r_data_valid;
  logic                     r_read_valid;
  logic                     r_bus_error;
  regval_t                  r_read_data;

  logic w_busy;
  logic w_expired;
  logic w_strobe;
  logic w_unused_addr_bits;

  assign w_busy             = state_is_busy(r_state);
  assign w_unused_addr_bits = ^{bus.address[1:0], bus.read_address[1:0]};

  data_memory_responder_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (!w_busy),
    .i_enable (w_busy),
    .o_expired(w_expired)
  );

  // Completion outputs default low every cycle; only the transition into
  // RESPOND raises them, which makes each pulse exactly one cycle wide.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_data_valid <= 1'b0;
      r_read_valid <= 1'b0;
      r_bus_error  <= 1'b0;
      r_read_data  <= '0;
    end else begin
      r_data_valid <= 1'b0;
      r_read_valid <= 1'b0;
      r_bus_error  <= 1'b0;
      r_read_data  <= '0;
      case (r_state)
        StIdle: begin
          if (bus.address_enable) begin
            r_addr  <= bus.address[ADDRESS_WIDTH+1:2];
            r_wdata <= bus.data;
            r_state <= StWriteCmd;
          end else if (bus.read_enable) begin
            r_addr  <= bus.read_address[ADDRESS_WIDTH+1:2];
            r_state <= StReadCmd;
          end
        end
        StWriteCmd: begin
          if (!bus.mem_wait_request) begin
            r_data_valid <= 1'b1;
            r_state      <= StRespond;
          end else if (w_expired) begin
            r_data_valid <= 1'b1;
            r_bus_error  <= 1'b1;
            r_state      <= StRespond;
          end
        end
        StReadCmd: begin
          if (!bus.mem_wait_request && bus.mem_read_data_valid) begin
            r_read_valid <= 1'b1;
            r_read_data  <= bus.mem_read_data;
            r_state      <= StRespond;
          end else if (w_expired) begin
            r_read_valid <= 1'b1;
            r_bus_error  <= 1'b1;
            r_state      <= StRespond;
          end else if (!bus.mem_wait_request) begin
            r_state <= StReadWait;
          end
        end
        StReadWait: begin
          if (bus.mem_read_data_valid) begin
            r_read_valid <= 1'b1;
            r_read_data  <= bus.mem_read_data;
            r_state      <= StRespond;
          end else if (w_expired) begin
            r_read_valid <= 1'b1;
            r_bus_error  <= 1'b1;
            r_state      <= StRespond;
          end
        end
        StRespond: r_state <= StIdle;
        default:   r_state <= StIdle;
      endcase
    end
  end

  // Bus strobes decode straight from the state register, so they can never overlap.
  assign w_strobe           = (r_state == StWriteCmd) || (r_state == StReadCmd);
  assign bus.mem_write      = (r_state == StWriteCmd);
  assign bus.mem_read       = (r_state == StReadCmd);
  assign bus.mem_address    = w_strobe ? r_addr : '0;
  assign bus.mem_write_data = (r_state == StWriteCmd) ? r_wdata : '0;

  assign bus.data_valid = r_data_valid;
  assign bus.read_valid = r_read_valid;
  assign bus.bus_error  = r_bus_error;
  assign bus.read_data  = r_read_data;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: single transactions from a vector table,
// then hand-written arbitration, latency, timeout and reset sequences.
module tb_data_memory_responder;

  logic clock;
  logic reset;

  data_memory_responder_if #(.ADDRESS_WIDTH(30)) busM ();
  data_memory_responder_if #(.ADDRESS_WIDTH(30)) busT ();

  data_memory_responder #(.ADDRESS_WIDTH(30), .TIMEOUT_CYCLES(255)) dut (
    .clock(clock), .reset(reset), .bus(busM)
  );

  data_memory_responder #(.ADDRESS_WIDTH(30), .TIMEOUT_CYCLES(4)) dutTo (
    .clock(clock), .reset(reset), .bus(busT)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        isRead;
    logic [31:0] addr;
    logic [31:0] value;
    logic [31:0] expMemAddr;
  } vec_t;

  vec_t vecs[6];

  int assertCount = 0;
  int failCount   = 0;

  int cyc, nWr, nRd, nOverlap, nErr, nDv, nRv, dvCyc, rvCyc, writesLeft;
  logic [31:0] lastRd, lastWrAddr, lastWrData;
  logic autoBus;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic clearStats();
    cyc = 0; nWr = 0; nRd = 0; nOverlap = 0; nErr = 0; nDv = 0; nRv = 0;
    dvCyc = -1; rvCyc = -1; lastRd = '0; lastWrAddr = '0; lastWrData = '0;
  endtask

  // One clock of the main bus with a requester that drops or reloads on completion.
  task automatic runCycle();
    tick();
    cyc++;
    if (busM.mem_write) begin
      nWr++;
      lastWrAddr = 32'(busM.mem_address);
      lastWrData = busM.mem_write_data;
    end
    if (busM.mem_read) nRd++;
    if (busM.mem_write && busM.mem_read) nOverlap++;
    if (busM.bus_error) nErr++;
    if (busM.data_valid) begin
      nDv++;
      dvCyc = cyc;
      writesLeft--;
      if (writesLeft > 0) begin
        busM.address = busM.address + 32'd4;
        busM.data    = busM.data + 32'd1;
      end else begin
        busM.address_enable = 1'b0;
      end
    end
    if (busM.read_valid) begin
      nRv++;
      rvCyc  = cyc;
      lastRd = busM.read_data;
      busM.read_enable = 1'b0;
    end
    if (autoBus) begin
      busM.mem_wait_request    = 1'b0;
      busM.mem_read_data_valid = busM.mem_read;
    end
  endtask

  // Zero-wait, zero-latency transaction with cycle-by-cycle checks.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    busM.mem_wait_request    = 1'b0;
    busM.mem_read_data_valid = 1'b0;
    if (v.isRead) begin
      busM.read_enable  = 1'b1;
      busM.read_address = v.addr;
    end else begin
      busM.address_enable = 1'b1;
      busM.address        = v.addr;
      busM.data           = v.value;
    end
    checkOutput({tag, " idle strobes"}, 32'(busM.mem_write | busM.mem_read), 32'd0);
    tick();
    checkOutput({tag, " cmd mem_write"}, 32'(busM.mem_write), 32'(!v.isRead));
    checkOutput({tag, " cmd mem_read"}, 32'(busM.mem_read), 32'(v.isRead));
    checkOutput({tag, " cmd mem_address"}, 32'(busM.mem_address), v.expMemAddr);
    if (!v.isRead) checkOutput({tag, " cmd mem_write_data"}, busM.mem_write_data, v.value);
    checkOutput({tag, " cmd no completion"}, 32'(busM.data_valid | busM.read_valid), 32'd0);
    if (v.isRead) begin
      busM.mem_read_data_valid = 1'b1;
      busM.mem_read_data       = v.value;
    end
    tick();
    checkOutput({tag, " resp data_valid"}, 32'(busM.data_valid), 32'(!v.isRead));
    checkOutput({tag, " resp read_valid"}, 32'(busM.read_valid), 32'(v.isRead));
    checkOutput({tag, " resp read_data"}, busM.read_data, v.isRead ? v.value : 32'd0);
    checkOutput({tag, " resp bus_error"}, 32'(busM.bus_error), 32'd0);
    checkOutput({tag, " resp strobes"}, 32'(busM.mem_write | busM.mem_read), 32'd0);
    busM.address_enable      = 1'b0;
    busM.read_enable         = 1'b0;
    busM.mem_read_data_valid = 1'b0;
    tick();
    checkOutput({tag, " after pulse"}, 32'(busM.data_valid | busM.read_valid), 32'd0);
    checkOutput({tag, " after read_data"}, busM.read_data, 32'd0);
  endtask

  initial begin
    int wrCycles, rdCycles, dvAt, rvAt, dvCount, rvCount;
    logic errAt;
    logic [31:0] rdAt;

    vecs[0] = '{1'b0, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0004};
    vecs[1] = '{1'b0, 32'h0000_0013, 32'h0000_0001, 32'h0000_0004};
    vecs[2] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0008};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 32'h3FFF_FFFF};
    vecs[4] = '{1'b0, 32'h8000_0004, 32'hFFFF_FFFF, 32'h2000_0001};
    vecs[5] = '{1'b1, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000};

    autoBus = 1'b0;
    writesLeft = 0;
    clearStats();
    reset = 1'b1;
    busM.address_enable = 0; busM.address = '0; busM.data = '0;
    busM.read_enable = 0; busM.read_address = '0;
    busM.mem_wait_request = 0; busM.mem_read_data = '0; busM.mem_read_data_valid = 0;
    busT.address_enable = 0; busT.address = '0; busT.data = '0;
    busT.read_enable = 0; busT.read_address = '0;
    busT.mem_wait_request = 0; busT.mem_read_data = '0; busT.mem_read_data_valid = 0;
    tick();
    tick();
    checkOutput("reset data_valid", 32'(busM.data_valid), 32'd0);
    checkOutput("reset read_valid", 32'(busM.read_valid), 32'd0);
    checkOutput("reset read_data", busM.read_data, 32'd0);
    checkOutput("reset bus_error", 32'(busM.bus_error), 32'd0);
    checkOutput("reset strobes", 32'(busM.mem_write | busM.mem_read), 32'd0);
    checkOutput("reset mem_address", 32'(busM.mem_address), 32'd0);
    checkOutput("reset mem_write_data", busM.mem_write_data, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

    // Read with two wait states and data arriving three cycles after acceptance.
    clearStats();
    busM.read_enable = 1'b1; busM.read_address = 32'h20;
    busM.mem_wait_request = 1'b1; busM.mem_read_data = 32'h1234_5678;
    for (int i = 0; i < 12; i++) begin
      runCycle();
      busM.mem_wait_request    = (cyc <= 2);
      busM.mem_read_data_valid = (cyc == 6);
    end
    checkOutput("lat mem_read cycles", 32'(nRd), 32'd3);
    checkOutput("lat read_valid count", 32'(nRv), 32'd1);
    checkOutput("lat read_valid cycle", 32'(rvCyc), 32'd7);
    checkOutput("lat read_data", lastRd, 32'h1234_5678);
    checkOutput("lat bus_error", 32'(nErr), 32'd0);
    busM.mem_read_data_valid = 1'b0;

    // Simultaneous write and read: write first, read once the write has responded.
    clearStats();
    autoBus = 1'b1; writesLeft = 1;
    busM.mem_wait_request = 1'b0; busM.mem_read_data_valid = 1'b0;
    busM.address_enable = 1'b1; busM.address = 32'h200; busM.data = 32'h1111_2222;
    busM.read_enable = 1'b1; busM.read_address = 32'h300; busM.mem_read_data = 32'h7777_8888;
    for (int i = 0; i < 10; i++) runCycle();
    checkOutput("sim data_valid cycle", 32'(dvCyc), 32'd2);
    checkOutput("sim read_valid cycle", 32'(rvCyc), 32'd5);
    checkOutput("sim write cmds", 32'(nWr), 32'd1);
    checkOutput("sim read cmds", 32'(nRd), 32'd1);
    checkOutput("sim overlap", 32'(nOverlap), 32'd0);
    checkOutput("sim read_data", lastRd, 32'h7777_8888);
    checkOutput("sim write addr", lastWrAddr, 32'h80);

    // Back-to-back writes: second request held through RESPOND is issued once.
    clearStats();
    writesLeft = 2;
    busM.address_enable = 1'b1; busM.address = 32'h400; busM.data = 32'h0000_000A;
    for (int i = 0; i < 10; i++) runCycle();
    checkOutput("b2b write cmds", 32'(nWr), 32'd2);
    checkOutput("b2b data_valid count", 32'(nDv), 32'd2);
    checkOutput("b2b last data_valid cycle", 32'(dvCyc), 32'd5);
    checkOutput("b2b second addr", lastWrAddr, 32'h101);
    checkOutput("b2b second data", lastWrData, 32'h0000_000B);

    // Reset while waiting for read data abandons the read silently.
    clearStats();
    autoBus = 1'b0;
    busM.mem_wait_request = 1'b0; busM.mem_read_data_valid = 1'b0;
    busM.read_enable = 1'b1; busM.read_address = 32'h40;
    runCycle();
    runCycle();
    checkOutput("rst read_wait mem_read", 32'(busM.mem_read), 32'd0);
    reset = 1'b1;
    busM.read_enable = 1'b0;
    busM.mem_read_data_valid = 1'b1; busM.mem_read_data = 32'h5555_AAAA;
    runCycle();
    checkOutput("rst read_valid", 32'(busM.read_valid), 32'd0);
    checkOutput("rst read_data", busM.read_data, 32'd0);
    checkOutput("rst strobes", 32'(busM.mem_write | busM.mem_read), 32'd0);
    checkOutput("rst mem_address", 32'(busM.mem_address), 32'd0);
    reset = 1'b0;
    busM.mem_read_data_valid = 1'b0;
    runCycle();
    runCycle();
    checkOutput("rst no late read_valid", 32'(nRv), 32'd0);
    clearStats();
    autoBus = 1'b1; writesLeft = 1;
    busM.address_enable = 1'b1; busM.address = 32'h100; busM.data = 32'h0BAD_CAFE;
    for (int i = 0; i < 5; i++) runCycle();
    checkOutput("post-rst data_valid cycle", 32'(dvCyc), 32'd2);
    checkOutput("post-rst write cmds", 32'(nWr), 32'd1);
    checkOutput("post-rst write addr", lastWrAddr, 32'h40);
    checkOutput("post-rst write data", lastWrData, 32'h0BAD_CAFE);
    checkOutput("post-rst bus_error", 32'(nErr), 32'd0);

    // Write timeout on the 4-cycle instance, followed by a stray read strobe in IDLE.
    wrCycles = 0; dvAt = -1; dvCount = 0; rvCount = 0; errAt = 1'b0;
    busT.address_enable = 1'b1; busT.address = 32'h10; busT.data = 32'h55;
    busT.mem_wait_request = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (busT.mem_write) wrCycles++;
      if (busT.read_valid) rvCount++;
      if (busT.data_valid) begin
        dvCount++;
        if (dvAt < 0) begin dvAt = c; errAt = busT.bus_error; end
        busT.address_enable = 1'b0;
      end
      busT.mem_read_data_valid = (c == 7);
      busT.mem_read_data       = 32'hDEAD_BEEF;
    end
    checkOutput("to wr strobe cycles", 32'(wrCycles), 32'd4);
    checkOutput("to wr data_valid cycle", 32'(dvAt), 32'd5);
    checkOutput("to wr bus_error", 32'(errAt), 32'd1);
    checkOutput("to wr data_valid count", 32'(dvCount), 32'd1);
    checkOutput("to wr stray read_valid", 32'(rvCount), 32'd0);

    // Read timeout: accepted but data never returns; late data is discarded.
    rdCycles = 0; rvAt = -1; rvCount = 0; errAt = 1'b0; rdAt = 32'hFFFF_FFFF;
    busT.mem_wait_request = 1'b0; busT.mem_read_data_valid = 1'b0;
    busT.read_enable = 1'b1; busT.read_address = 32'h44;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (busT.mem_read) rdCycles++;
      if (busT.read_valid) begin
        rvCount++;
        if (rvAt < 0) begin rvAt = c; errAt = busT.bus_error; rdAt = busT.read_data; end
        busT.read_enable = 1'b0;
      end
      busT.mem_read_data_valid = (c == 7);
    end
    checkOutput("to rd strobe cycles", 32'(rdCycles), 32'd1);
    checkOutput("to rd read_valid cycle", 32'(rvAt), 32'd5);
    checkOutput("to rd bus_error", 32'(errAt), 32'd1);
    checkOutput("to rd read_data", rdAt, 32'd0);
    checkOutput("to rd read_valid count", 32'(rvCount), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
